// File: rtl/bus_write_arbiter_pkg.sv
// Shared types and constants for the bus write arbiter.
// State encodings, destination codes, widths and small decode helpers.
package bus_write_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int DEST_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [DEST_W-1:0] DEST_A = 2'd0;
  localparam logic [DEST_W-1:0] DEST_B = 2'd1;
  localparam logic [DEST_W-1:0] DEST_C = 2'd2;
  localparam logic [DEST_W-1:0] DEST_D = 2'd3;

  // Enable vector ordered {D, C, B, A}.
  function automatic logic [NUM_REQ-1:0] dest_en(
    input logic [DEST_W-1:0] d
  );
    dest_en = '0;
    unique case (d)
      DEST_A: dest_en = 4'b0001;
      DEST_B: dest_en = 4'b0010;
      DEST_C: dest_en = 4'b0100;
      DEST_D: dest_en = 4'b1000;
    endcase
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [1:0] i
  );
    onehot = 4'b0001 << i;
  endfunction

endpackage

// File: rtl/bus_write_arbiter_if.sv
// Requester/bus bundle between requesters, arbiter and register file.
// slave: arbiter side; master: requester/register-file side.
interface bus_write_arbiter_if;
  import bus_write_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*DATA_W-1:0] Req_Data;
  logic [NUM_REQ*DEST_W-1:0] Req_Dest;
  logic [NUM_REQ-1:0]        Ack;
  logic [NUM_REQ-1:0]        Grant;
  logic                      Busy;
  logic [DATA_W-1:0]         Data_Bus;
  logic                      A_EN;
  logic                      B_EN;
  logic                      C_EN;
  logic                      D_EN;
  logic [NUM_REQ*DATA_W-1:0] Grant_Count;

  modport slave (
    input  Req, Req_Data, Req_Dest,
    output Ack, Grant, Busy, Data_Bus,
    output A_EN, B_EN, C_EN, D_EN,
    output Grant_Count
  );

  modport master (
    output Req, Req_Data, Req_Dest,
    input  Ack, Grant, Busy, Data_Bus,
    input  A_EN, B_EN, C_EN, D_EN,
    input  Grant_Count
  );

endinterface

// File: rtl/bus_write_arbiter_rr_pick4.sv
// Combinational 4-way round-robin selector.
// Req: requests, last: previous winner; winner/valid: pick result.
module rr_pick4 (
  input  logic [3:0] Req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // Scan last+1, last+2, ... wrapping; 2-bit add does the modulo.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!valid && Req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_write_arbiter.sv
// Round-robin write arbiter/sequencer for the shared 16-bit data bus.
// Ports: Clock, Reset (async low), bus (slave modport). Option: BUS_ARB_STATS_EN.
module bus_write_arbiter
  import bus_write_arbiter_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  bus_write_arbiter_if.slave   bus
);

  state_t              state;
  logic [1:0]          last_q;
  logic [1:0]          win_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  en_q;
  logic                busy_q;
  logic [DATA_W-1:0]   bus_q;

  logic [1:0]          pick_win;
  logic                pick_vld;
  logic [DATA_W-1:0]   pick_data;
  logic [DEST_W-1:0]   pick_dest;

  rr_pick4 u_pick (
    .Req    (bus.Req),
    .last   (last_q),
    .winner (pick_win),
    .valid  (pick_vld)
  );

  assign pick_data =
    bus.Req_Data[int'(pick_win)*DATA_W +: DATA_W];
  assign pick_dest =
    bus.Req_Dest[int'(pick_win)*DEST_W +: DEST_W];

  // Bus data and enables are loaded on entry to DRIVE,
  // so they are valid for exactly the DRIVE cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      last_q  <= 2'd3;
      win_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      bus_q   <= '0;
    end else begin
      ack_q <= '0;
      en_q  <= '0;
      bus_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state   <= ST_DRIVE;
            win_q   <= pick_win;
            grant_q <= onehot(pick_win);
            bus_q   <= pick_data;
            en_q    <= dest_en(pick_dest);
            busy_q  <= 1'b1;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          state <= ST_ACK;
          ack_q <= onehot(win_q);
        end
        ST_ACK: begin
          state   <= ST_IDLE;
          last_q  <= win_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ack      = ack_q;
  assign bus.Grant    = grant_q;
  assign bus.Busy     = busy_q;
  assign bus.Data_Bus = bus_q;
  assign bus.A_EN     = en_q[0];
  assign bus.B_EN     = en_q[1];
  assign bus.C_EN     = en_q[2];
  assign bus.D_EN     = en_q[3];

`ifdef BUS_ARB_STATS_EN
  logic [NUM_REQ-1:0][DATA_W-1:0] cnt_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (state == ST_ACK) begin
      if (cnt_q[win_q] != '1) begin
        cnt_q[win_q] <= cnt_q[win_q] + 1'b1;
      end
    end
  end

  assign bus.Grant_Count = cnt_q;
`else
  assign bus.Grant_Count = '0;
`endif

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Self-checking bench for bus_write_arbiter.
// Table vectors plus a write scoreboard fed from a register-file model.
module tb_bus_write_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  bus_write_arbiter_if bus ();

  bus_write_arbiter dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0]  dest;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          r;
    logic [15:0] data;
    logic [1:0]  dest;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_en;
  } vec_t;

  wr_t         exp_q[$];
  logic [15:0] regs[4];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  always @(posedge Clock) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  function automatic logic [3:0] ens();
    return {bus.D_EN, bus.C_EN, bus.B_EN, bus.A_EN};
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] e);
    if (e[3]) return 2'd3;
    if (e[2]) return 2'd2;
    if (e[1]) return 2'd1;
    return 2'd0;
  endfunction

  // Register-file model + scoreboard: every write seen
  // on the bus must match the next expected write.
  always @(negedge Clock) begin
    if (Reset) begin
      if ($countones(ens()) > 1)
        chk("en_onehot", 64'(ens()), 64'd0);
      if (ens() != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(ens()), 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("sb_write", {46'd0, enc(ens()), bus.Data_Bus},
              {46'd0, e});
        end
        regs[enc(ens())] = bus.Data_Bus;
      end
    end
  end

  task automatic set_req(input int r,
                         input logic [15:0] d,
                         input logic [1:0] dst);
    bus.Req_Data[r*16 +: 16] = d;
    bus.Req_Dest[r*2 +: 2]   = dst;
    bus.Req[r]               = 1'b1;
  endtask

  task automatic wait_any_ack(output logic [3:0] a);
    a = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (bus.Ack != 4'd0) begin
        a = bus.Ack;
        break;
      end
    end
  endtask

  task automatic serve(input int r,
                       input logic [15:0] d,
                       input logic [1:0] dst);
    logic [3:0] a;
    @(negedge Clock);
    set_req(r, d, dst);
    exp_q.push_back({dst, d});
    wait_any_ack(a);
    chk("serve_ack", 64'(a), 64'(4'b0001 << r));
    bus.Req[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt[5];
    logic [3:0] a;
    int         t[4];
    bit         ack_seen;

    vt[0] = '{2, 16'h00A5, 2'd1, 4'b0100, 4'b0010};
    vt[1] = '{0, 16'h1234, 2'd3, 4'b0001, 4'b1000};
    vt[2] = '{3, 16'hFFFF, 2'd0, 4'b1000, 4'b0001};
    vt[3] = '{1, 16'h0000, 2'd2, 4'b0010, 4'b0100};
    vt[4] = '{1, 16'h8001, 2'd1, 4'b0010, 4'b0010};

    for (int i = 0; i < 4; i++) regs[i] = 16'h0;
    bus.Req      = 4'hF;
    bus.Req_Data = 64'h4444_3333_2222_1111;
    bus.Req_Dest = {2'd3, 2'd2, 2'd1, 2'd0};

    // Reset held with all requesting
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_grant", 64'(bus.Grant), 64'd0);
    chk("rst_ack", 64'(bus.Ack), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_bus", 64'(bus.Data_Bus), 64'd0);
    chk("rst_en", 64'(ens()), 64'd0);

    // Rotation 0,1,2,3 at one write per 3 cycles
    for (int k = 0; k < 4; k++)
      exp_q.push_back({2'(k), 16'(16'h1111 * (k + 1))});
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(a);
      t[k] = cyc;
      chk("rot_ack", 64'(a), 64'(4'b0001 << k));
      chk("rot_grant", 64'(bus.Grant), 64'(4'b0001 << k));
      bus.Req[k] = 1'b0;
      if (k > 0) chk("rot_period", 64'(t[k] - t[k-1]), 64'd3);
    end
    @(negedge Clock);
    chk("rot_regA", 64'(regs[0]), 64'h1111);
    chk("rot_regB", 64'(regs[1]), 64'h2222);
    chk("rot_regC", 64'(regs[2]), 64'h3333);
    chk("rot_regD", 64'(regs[3]), 64'h4444);

    // Single-request vectors, cycle exact
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      set_req(vt[i].r, vt[i].data, vt[i].dest);
      exp_q.push_back({vt[i].dest, vt[i].data});
      @(negedge Clock);
      chk("v_grant", 64'(bus.Grant), 64'(vt[i].exp_grant));
      chk("v_busy_drv", 64'(bus.Busy), 64'd1);
      chk("v_en", 64'(ens()), 64'(vt[i].exp_en));
      chk("v_bus", 64'(bus.Data_Bus), 64'(vt[i].data));
      @(negedge Clock);
      chk("v_ack", 64'(bus.Ack), 64'(vt[i].exp_grant));
      chk("v_en_ack", 64'(ens()), 64'd0);
      chk("v_bus_ack", 64'(bus.Data_Bus), 64'd0);
      chk("v_busy_ack", 64'(bus.Busy), 64'd1);
      bus.Req[vt[i].r] = 1'b0;
      @(negedge Clock);
      chk("v_busy_idle", 64'(bus.Busy), 64'd0);
      chk("v_grant_idle", 64'(bus.Grant), 64'd0);
      chk("v_ack_idle", 64'(bus.Ack), 64'd0);
      chk("v_reg", 64'(regs[vt[i].dest]), 64'(vt[i].data));
    end

    // Same destination, last=2: requester 3 then 0
    serve(2, 16'h0777, 2'd2);
    @(negedge Clock);
    set_req(0, 16'hBEEF, 2'd2);
    set_req(3, 16'hCAFE, 2'd2);
    exp_q.push_back({2'd2, 16'hCAFE});
    exp_q.push_back({2'd2, 16'hBEEF});
    wait_any_ack(a);
    chk("col_first", 64'(a), 64'h8);
    bus.Req[3] = 1'b0;
    wait_any_ack(a);
    chk("col_second", 64'(a), 64'h1);
    bus.Req[0] = 1'b0;
    repeat (2) @(negedge Clock);
    chk("col_regC", 64'(regs[2]), 64'hBEEF);

    // Reset during DRIVE aborts the transfer
    @(negedge Clock);
    set_req(1, 16'h5555, 2'd3);
    @(posedge Clock);
    #1;
    chk("ab_pre_en", 64'(ens()), 64'h8);
    chk("ab_pre_bus", 64'(bus.Data_Bus), 64'h5555);
    Reset = 1'b0;
    #1;
    chk("ab_en", 64'(ens()), 64'd0);
    chk("ab_bus", 64'(bus.Data_Bus), 64'd0);
    chk("ab_grant", 64'(bus.Grant), 64'd0);
    chk("ab_busy", 64'(bus.Busy), 64'd0);
    bus.Req = 4'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    ack_seen = 1'b0;
    repeat (5) begin
      @(negedge Clock);
      if (bus.Ack != 4'd0) ack_seen = 1'b1;
    end
    chk("ab_no_ack", 64'(ack_seen), 64'd0);
    set_req(0, 16'h0101, 2'd0);
    set_req(3, 16'h0303, 2'd3);
    exp_q.push_back({2'd0, 16'h0101});
    exp_q.push_back({2'd3, 16'h0303});
    wait_any_ack(a);
    chk("ab_prio0", 64'(a), 64'h1);
    bus.Req[0] = 1'b0;
    wait_any_ack(a);
    chk("ab_prio3", 64'(a), 64'h8);
    bus.Req[3] = 1'b0;

`ifdef BUS_ARB_STATS_EN
    for (int i = 0; i < 5; i++)
      serve(1, 16'(16'h0A00 + i), 2'd1);
    @(negedge Clock);
    chk("cnt5", 64'(bus.Grant_Count[31:16]), 64'd5);
    force dut.cnt_q = 64'h0000_0000_FFFF_0000;
    #1;
    release dut.cnt_q;
    serve(1, 16'h0BBB, 2'd1);
    @(negedge Clock);
    chk("cnt_sat", 64'(bus.Grant_Count[31:16]), 64'hFFFF);
`else
    chk("gcnt_zero", bus.Grant_Count, 64'd0);
`endif

    repeat (2) @(negedge Clock);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_write_arbiter.md
Name: bus_write_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit register-file data bus.
- Four requesters compete to write one of the four bus registers (A/B/C/D).
- The block selects a winner, drives Data_Bus, and pulses exactly one register enable (A_EN..D_EN) for one cycle.
- It then acknowledges the winning requester.
- It sits between the requester logic and bus_16_bit, and is the only driver of that bus.

Parameters:
- NUM_REQ, 4: number of requesters; only 4 is supported.
- DATA_W, 16: bus data width; must match the register width.
- DEST_W, 2: width of the destination select (0=A, 1=B, 2=C, 3=D).

Ports:
- Clock  input  1  system clock; rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  4  per-requester write request; level, held until Ack.
- Req_Data  input  64  requester i data on bits [16i+15:16i].
- Req_Dest  input  8  requester i destination on bits [2i+1:2i].
- Ack  output  4  one-cycle pulse to the served requester.
- Grant  output  4  one-hot current owner; 0 when idle.
- Busy  output  1  high while in DRIVE or ACK.
- Data_Bus  output  16  bus data to the register file.
- A_EN, B_EN, C_EN, D_EN  output  1 each  register write enables.
- Grant_Count  output  64  per-requester grant counters (optional feature only).

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE.
  - Ack, Grant, Busy, Data_Bus, all *_EN = 0.
  - Round-robin pointer last=3, so requester 0 has first priority.
  - Reset asserted mid-transfer aborts it; no enable or Ack is issued afterwards.
- FSM states: IDLE -> DRIVE -> ACK -> IDLE. Each state lasts exactly one cycle; no wait states.
- IDLE:
  - If Req != 0, the winner is the first set bit scanning last+1, last+2, ... modulo 4.
  - Register Grant=one-hot(winner), latch Req_Data slice and Req_Dest slice, go to DRIVE.
  - If Req == 0, stay in IDLE with all outputs 0.
- DRIVE:
  - Data_Bus = latched data.
  - Exactly one enable is high, selected by the latched destination.
  - Busy=1. Go to ACK.
- ACK:
  - Ack[winner]=1 for this cycle only; Data_Bus=0; all enables 0; Busy=1.
  - last <= winner. Go to IDLE.
  - Grant clears on the return to IDLE.
- Timing: latency from Req sampled in IDLE to register update is 2 edges. Throughput is one write per 3 cycles; back-to-back requests re-arbitrate in IDLE.
- Outside DRIVE: Data_Bus=16'h0 and all enables are 0. The bus is never tri-stated.
- Invariant: A_EN+B_EN+C_EN+D_EN <= 1 every cycle.
- Requester rules:
  - Hold Req, Req_Data and Req_Dest stable until Ack.
  - Data changes after latching are ignored.
  - Req dropped while not granted = withdrawn, no Ack.
  - Requester should deassert Req in the cycle after Ack.
  - If Req is still high in IDLE after its Ack, it is treated as a new request at lowest priority.
- Simultaneous requests: resolved strictly by rotation. Two requesters targeting the same register are served sequentially; the later write wins.
- All outputs are registered; there are no combinational paths from Req to outputs.

Optional Feature:
- Macro: BUS_ARB_STATS_EN.
- When defined:
  - Four 16-bit saturating counters, one per requester, each incremented in the ACK cycle for the served requester.
  - Saturate at 16'hFFFF; reset to 0.
  - Exposed on Grant_Count, requester i on bits [16i+15:16i].
- When undefined: Grant_Count is tied to 0 and no counter flops exist. FSM behaviour is identical either way.

Decomposition:
- Shared package/include file holds:
  - State encodings ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_ACK=2'd2.
  - DEST_A..DEST_D constants (0..3).
  - DATA_W=16.
- One sub-module: rr_pick4.
  - Combinational round-robin selector.
  - Inputs: Req[3:0], last[1:0]. Outputs: winner[1:0], valid.
  - Instantiated once.

Test Plan:
- Reset with Req=4'hF asserted -> all outputs 0 during reset. First grant goes to requester 0 (Grant=4'b0001), then requesters 1, 2, 3 in order.
- Single request: Req[2]=1, data 16'h00A5, dest=1 -> next cycle DRIVE with Data_Bus=16'h00A5 and B_EN=1 only. Next cycle Ack=4'b0100. RegB=16'h00A5 in bus_16_bit.
- All four requesting continuously with dests 0..3 and data 16'h1111..16'h4444:
  - Grants rotate 0,1,2,3, one per 3 cycles.
  - Finally RegA..RegD = 16'h1111..16'h4444.
  - Never more than one *_EN high.
- Requesters 0 and 3 both target C (0: 16'hBEEF, 3: 16'hCAFE), last=2 -> requester 3 is served first, then requester 0. RegC ends at 16'hBEEF.
- Reset pulsed low during DRIVE -> enables and Data_Bus drop to 0 immediately, no Ack is issued, and the FSM restarts in IDLE with priority at requester 0.
- With BUS_ARB_STATS_EN: 5 grants to requester 1 -> Grant_Count[31:16]=5. With the counter preloaded to 16'hFFFF via force, a further grant leaves it at 16'hFFFF.
